// File: rtl/if_stage.sv
// RV32I instruction fetch stage: PC, imem valid/ack port, skid buffer, IF/ID.
// Define IF_PERF_CNT_EN to add fetch/bubble performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall_f,
  input  logic        i_flush_d,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pcplus4_d,
  output logic        o_valid_d
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetch,
  output logic [31:0] o_perf_bubble
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_BUFFERED,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  state_t      state, state_n;
  logic        run;
  logic [31:0] pc_f, pc_n;
  logic [31:0] skid_q, skid_n;
  logic [31:0] drain_q, drain_n;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        take;
  logic [31:0] take_instr;
  if_id_t      ifid_q, ifid_n;
  if_id_t      bubble;

  assign pc_plus4 = pc_f + 32'd4;
  assign target   = i_redirect_pc & ~32'h3;

  // run gates the first request to the cycle after reset release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run     <= 1'b0;
      state   <= S_FETCH;
      pc_f    <= RESET_PC;
      skid_q  <= 32'h0;
      drain_q <= 32'h0;
    end else begin
      run     <= 1'b1;
      state   <= state_n;
      pc_f    <= pc_n;
      skid_q  <= skid_n;
      drain_q <= drain_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc_f;
    skid_n      = skid_q;
    drain_n     = drain_q;
    o_imem_req  = 1'b0;
    o_imem_addr = pc_f;
    take        = 1'b0;
    take_instr  = i_imem_rdata;
    if (run) begin
      unique case (state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          if (i_redirect) begin
            pc_n = target;
            if (!i_imem_ack) begin
              drain_n = pc_f;
              state_n = S_DRAIN;
            end
          end else if (i_imem_ack) begin
            if (i_stall_f) begin
              skid_n  = i_imem_rdata;
              state_n = S_BUFFERED;
            end else begin
              take = 1'b1;
              pc_n = pc_plus4;
            end
          end
        end
        S_BUFFERED: begin
          if (i_redirect) begin
            pc_n    = target;
            state_n = S_FETCH;
          end else if (!i_stall_f) begin
            take       = 1'b1;
            take_instr = skid_q;
            pc_n       = pc_plus4;
            state_n    = S_FETCH;
          end
        end
        S_DRAIN: begin
          o_imem_req  = 1'b1;
          o_imem_addr = drain_q;
          if (i_redirect) pc_n = target;
          if (i_imem_ack) state_n = S_FETCH;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

  // a bubble keeps the previous pc fields
  always_comb begin
    bubble       = ifid_q;
    bubble.instr = NOP_INSTR;
    bubble.valid = 1'b0;
  end

  always_comb begin
    ifid_n = ifid_q;
    if (!run) begin
      ifid_n = ifid_q;
    end else if (i_flush_d) begin
      ifid_n = bubble;
    end else if (i_stall_f) begin
      ifid_n = ifid_q;
    end else if (take) begin
      ifid_n.instr   = take_instr;
      ifid_n.pc      = pc_f;
      ifid_n.pcplus4 = pc_plus4;
      ifid_n.valid   = 1'b1;
    end else begin
      ifid_n = bubble;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ifid_q <= '{instr: NOP_INSTR, pc: 32'h0,
                  pcplus4: 32'h0, valid: 1'b0};
    end else begin
      ifid_q <= ifid_n;
    end
  end

  assign o_instr_d   = ifid_q.instr;
  assign o_pc_d      = ifid_q.pc;
  assign o_pcplus4_d = ifid_q.pcplus4;
  assign o_valid_d   = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
  logic ld_en;

  assign ld_en = run && !i_flush_d && !i_stall_f;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_fetch  <= 32'h0;
      o_perf_bubble <= 32'h0;
    end else if (ld_en) begin
      if (take) o_perf_fetch <= o_perf_fetch + 32'd1;
      else o_perf_bubble <= o_perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core.
- Owns the fetch PC and drives a valid/ack instruction-memory port.
- Registers each fetched word into the IF/ID pipeline register. The decoder and immediate extender consume that register in ID.
- Handles stalls via a 1-entry skid buffer, plus redirects, flushes, and discarding of stale responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, encoding driven on o_instr_d for bubbles (addi x0,x0,0)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_stall_f  in  1  hazard unit: hold PC and IF/ID register
i_flush_d  in  1  load bubble into IF/ID register
i_redirect  in  1  branch/jump resolved taken; fetch from i_redirect_pc
i_redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00)
o_imem_req  out  1  fetch request valid
o_imem_addr  out  32  fetch address, word aligned
i_imem_ack  in  1  response valid this cycle (same-cycle ack allowed)
i_imem_rdata  in  32  instruction word, valid with ack
o_instr_d  out  32  IF/ID instruction
o_pc_d  out  32  IF/ID PC
o_pcplus4_d  out  32  IF/ID PC+4
o_valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, i_rst_n=0):
  - pc_f=RESET_PC; state=FETCH; o_imem_req=0.
  - o_valid_d=0; o_instr_d=NOP_INSTR; o_pc_d=0; o_pcplus4_d=0.
  - Buffer is cleared and the drain address is 0.
  - First request is issued in the first cycle after release.
- Handshake: once o_imem_req=1 and no ack, o_imem_addr is held stable until i_imem_ack. One outstanding request maximum.
- Arithmetic: PC+4 is 32-bit modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- FSM states:
  - FETCH:
    - req=1, addr=pc_f.
    - ack & !redirect & !stall: IF/ID <= {rdata, pc_f, pc_f+4, valid=1}; pc_f += 4.
    - ack & stall & !redirect: buf <= rdata; -> BUFFERED; pc_f held.
    - !ack & !stall & !redirect: IF/ID <= bubble (valid=0, NOP_INSTR; pc fields hold).
    - redirect & ack: response discarded; pc_f <= target; stay FETCH.
    - redirect & !ack: drain_addr <= pc_f; pc_f <= target; -> DRAIN.
  - BUFFERED:
    - req=0.
    - !stall & !redirect: IF/ID <= {buf, pc_f, pc_f+4, 1}; pc_f += 4; -> FETCH.
    - redirect: buffer discarded; pc_f <= target; -> FETCH.
  - DRAIN:
    - req=1, addr=drain_addr.
    - ack: data discarded; -> FETCH.
    - A further redirect updates pc_f and stays in DRAIN.
    - IF/ID loads bubbles unless stalled.
- IF/ID priority: i_flush_d > i_stall_f > load.
  - Flush always writes a bubble, even while stalled.
  - Stall holds all four IF/ID outputs.
- Redirect never loads a valid instruction into IF/ID in the same cycle. The hazard unit pairs it with i_flush_d; the block does not depend on that.
- Latency: with zero-wait memory and no stall, the instruction at PC appears on o_instr_d the cycle after the request. Throughput is 1 per cycle.
- Reset mid-transaction: the outstanding request is abandoned and the state returns to the reset values. Memory is reset on the same net.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds o_perf_fetch[31:0], which counts cycles where IF/ID loads valid=1.
  - Adds o_perf_bubble[31:0], which counts cycles where IF/ID loads a bubble, excluding flush.
  - Both counters reset to 0 asynchronously and wrap at 2^32.
- Not defined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Release reset, zero-wait memory returning addr^32'hA5A5_0000:
  - Requests at 0x0, 0x4, 0x8.
  - o_instr_d=0xA5A5_0000 with o_pc_d=0 one cycle after the first request; o_valid_d=1 each cycle thereafter.
- Ack at pc 0x8 while i_stall_f=1 for 3 cycles:
  - req=0 during the stall; IF/ID holds pc 0x4.
  - On stall release, o_pc_d=0x8 with the buffered word, and fetch resumes at 0xC.
- 2-wait-state memory, redirect to 0x100 on the request's first cycle:
  - addr stays at the old pc until ack.
  - That response never reaches IF/ID; the next request is 0x100.
- i_flush_d=1 with i_stall_f=1:
  - o_valid_d=0, o_instr_d=0x0000_0013.
- Redirect to 0xFFFF_FFFC, then sequential fetch:
  - o_pcplus4_d=0 and the next request address is 0x0.
- Assert i_rst_n=0 mid-wait:
  - o_imem_req=0 and o_valid_d=0 immediately.
  - After release, the first request is at RESET_PC.
